// File: rtl/line_loader.sv
// line_loader: turns "L<rr><hex pairs>\n" UART commands into frame-memory port A byte writes.
// One cycle from the low-nibble strobe to the write; no backpressure, every rx_valid strobe is consumed.
module line_loader #(
  parameter int ROWS           = 32,
  parameter int BYTES_PER_LINE = 128,
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_TICKS  = 4095,
  parameter int TIMEOUT_WIDTH  = 12
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            ram_data_out,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_write_enable,
  output logic                  ram_clk_enable,
  output logic                  busy,
  output logic                  line_done,
  output logic                  error,
  output logic [7:0]            lines_loaded
);

  localparam int IDX_W = $clog2(BYTES_PER_LINE);
  localparam int ROW_W = ADDR_WIDTH - IDX_W;

  typedef enum logic [2:0] {
    IDLE,
    ROW_HI,
    ROW_LO,
    DATA_HI,
    DATA_LO,
    TERM
  } state_t;

  state_t                   state_q;
  logic [3:0]               row_hi_q;
  logic [ROW_W-1:0]         row_q;
  logic [IDX_W-1:0]         idx_q;
  logic [3:0]               nib_hi_q;
  logic [TIMEOUT_WIDTH-1:0] tmo_q;
  logic [6:0]               row_num;
  logic                     row_ok;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= "0") && (c <= "9");
  endfunction

  function automatic logic is_hex(input logic [7:0] c);
    return is_digit(c) || ((c >= "A") && (c <= "F")) || ((c >= "a") && (c <= "f"));
  endfunction

  function automatic logic [3:0] hex_val(input logic [7:0] c);
    logic [3:0] v;
    if (is_digit(c))
      v = 4'(c - 8'h30);
    else if (c <= "F")
      v = 4'(c - 8'h37);
    else
      v = 4'(c - 8'h57);
    return v;
  endfunction

  // For an ASCII digit the low nibble is already the decimal value.
  always_comb begin
    row_num = 7'(row_hi_q) * 7'd10 + 7'(rx_data[3:0]);
    row_ok  = int'(row_num) < ROWS;
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q          <= IDLE;
      row_hi_q         <= '0;
      row_q            <= '0;
      idx_q            <= '0;
      nib_hi_q         <= '0;
      tmo_q            <= '0;
      ram_data_out     <= '0;
      ram_address      <= '0;
      ram_write_enable <= 1'b0;
      ram_clk_enable   <= 1'b0;
      line_done        <= 1'b0;
      error            <= 1'b0;
      lines_loaded     <= '0;
    end else begin
      ram_write_enable <= 1'b0;
      ram_clk_enable   <= 1'b0;
      line_done        <= 1'b0;
      error            <= 1'b0;

      // Inter-character watchdog; a strobe always restarts it, so it never races a command byte.
      if (state_q == IDLE || rx_valid) begin
        tmo_q <= '0;
      end else if (tmo_q == TIMEOUT_WIDTH'(TIMEOUT_TICKS - 1)) begin
        tmo_q   <= '0;
        error   <= 1'b1;
        state_q <= IDLE;
      end else begin
        tmo_q <= tmo_q + TIMEOUT_WIDTH'(1);
      end

      if (rx_valid) begin
        case (state_q)
          IDLE: begin
            if (rx_data == "L")
              state_q <= ROW_HI;
          end
          ROW_HI: begin
            if (is_digit(rx_data)) begin
              row_hi_q <= rx_data[3:0];
              state_q  <= ROW_LO;
            end else begin
              error   <= 1'b1;
              state_q <= IDLE;
            end
          end
          ROW_LO: begin
            if (is_digit(rx_data) && row_ok) begin
              row_q   <= ROW_W'(row_num);
              idx_q   <= '0;
              state_q <= DATA_HI;
            end else begin
              error   <= 1'b1;
              state_q <= IDLE;
            end
          end
          DATA_HI: begin
            if (is_hex(rx_data)) begin
              nib_hi_q <= hex_val(rx_data);
              state_q  <= DATA_LO;
            end else begin
              error   <= 1'b1;
              state_q <= IDLE;
            end
          end
          DATA_LO: begin
            if (is_hex(rx_data)) begin
              ram_data_out     <= {nib_hi_q, hex_val(rx_data)};
              ram_address      <= {row_q, idx_q};
              ram_write_enable <= 1'b1;
              ram_clk_enable   <= 1'b1;
              idx_q            <= idx_q + IDX_W'(1);
              state_q          <= (idx_q == IDX_W'(BYTES_PER_LINE - 1)) ? TERM : DATA_HI;
            end else begin
              error   <= 1'b1;
              state_q <= IDLE;
            end
          end
          TERM: begin
            if (rx_data == 8'h0A) begin
              line_done    <= 1'b1;
              lines_loaded <= lines_loaded + 8'd1;
              state_q      <= IDLE;
            end else if (rx_data != 8'h0D) begin
              error   <= 1'b1;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_line_loader.sv
// Randomized bench for line_loader against a string-scanning reference parser.
module tb_line_loader;
  localparam int ROWS = 32;
  localparam int BPL  = 128;
  localparam int AW   = 12;
  localparam int TMO  = 4095;

  logic          clk_in = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    ram_data_out;
  logic [AW-1:0] ram_address;
  logic          ram_write_enable;
  logic          ram_clk_enable;
  logic          busy;
  logic          line_done;
  logic          error;
  logic [7:0]    lines_loaded;

  typedef struct packed {
    logic [31:0]   cyc;
    logic [AW-1:0] addr;
    logic [7:0]    dat;
  } wr_t;

  wr_t  obs_wr[$], exp_wr[$];
  int   obs_err[$], exp_err[$], obs_done[$], exp_done[$];
  int   cyc = 0, checks = 0, errors = 0, ce_bad = 0, both_bad = 0, last_cc = 0;
  logic [7:0] exp_lines = 8'd0;
  bit   pending;

  line_loader #(
    .ROWS(ROWS), .BYTES_PER_LINE(BPL), .ADDR_WIDTH(AW),
    .TIMEOUT_TICKS(TMO), .TIMEOUT_WIDTH(12)
  ) dut (
    .clk_in(clk_in), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .ram_data_out(ram_data_out), .ram_address(ram_address),
    .ram_write_enable(ram_write_enable), .ram_clk_enable(ram_clk_enable),
    .busy(busy), .line_done(line_done), .error(error), .lines_loaded(lines_loaded)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Outputs are logged just after the edge that produced them, tagged with that edge's index.
  always @(posedge clk_in) begin
    #1;
    if (ram_write_enable === 1'b1) obs_wr.push_back(wr_t'{32'(cyc), ram_address, ram_data_out});
    if (ram_write_enable !== ram_clk_enable) ce_bad++;
    if (error === 1'b1) obs_err.push_back(cyc);
    if (line_done === 1'b1) obs_done.push_back(cyc);
    if (error === 1'b1 && line_done === 1'b1) both_bad++;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded its cycle budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic bit is_dig(input logic [7:0] c);
    return c >= 8'd48 && c <= 8'd57;
  endfunction

  function automatic bit is_hx(input logic [7:0] c);
    return is_dig(c) || (c >= 8'd65 && c <= 8'd70) || (c >= 8'd97 && c <= 8'd102);
  endfunction

  function automatic int hx(input logic [7:0] c);
    if (is_dig(c)) return int'(c) - 48;
    if (c >= 8'd97) return int'(c) - 87;
    return int'(c) - 55;
  endfunction

  function automatic string rhex(input int nbytes);
    string s = "";
    for (int i = 0; i < nbytes; i++) begin
      if ($urandom_range(1, 0) == 1) s = {s, $sformatf("%02x", $urandom_range(255, 0))};
      else s = {s, $sformatf("%02X", $urandom_range(255, 0))};
    end
    return s;
  endfunction

  // Reference: scan the command text; cc[i] is the edge that samples character i,
  // and every consequence of character i is expected to be visible right after that edge.
  task automatic model(input string s, input int cc[$]);
    int  i, n, row, h;
    bit  ok;
    i = 0; n = s.len(); pending = 0;
    while (i < n) begin
      if (s[i] != "L") begin i++; continue; end
      i++;
      if (i >= n) begin pending = 1; break; end
      if (!is_dig(s[i])) begin exp_err.push_back(cc[i]); i++; continue; end
      row = 10 * (int'(s[i]) - 48); i++;
      if (i >= n) begin pending = 1; break; end
      if (!is_dig(s[i])) begin exp_err.push_back(cc[i]); i++; continue; end
      row += int'(s[i]) - 48;
      if (row >= ROWS) begin exp_err.push_back(cc[i]); i++; continue; end
      i++;
      ok = 1;
      for (int b = 0; b < BPL && ok; b++) begin
        if (i >= n) begin pending = 1; ok = 0; end
        else if (!is_hx(s[i])) begin exp_err.push_back(cc[i]); i++; ok = 0; end
        else begin
          h = hx(s[i]); i++;
          if (i >= n) begin pending = 1; ok = 0; end
          else if (!is_hx(s[i])) begin exp_err.push_back(cc[i]); i++; ok = 0; end
          else begin
            exp_wr.push_back(wr_t'{32'(cc[i]), AW'(row * BPL + b), 8'(h * 16 + hx(s[i]))});
            i++;
          end
        end
      end
      if (!ok) continue;
      while (i < n && s[i] == "\r") i++;
      if (i >= n) begin pending = 1; break; end
      if (s[i] == "\n") begin exp_done.push_back(cc[i]); exp_lines++; end
      else exp_err.push_back(cc[i]);
      i++;
    end
  endtask

  task automatic clear_obs();
    obs_wr.delete(); exp_wr.delete(); obs_err.delete(); exp_err.delete();
    obs_done.delete(); exp_done.delete();
  endtask

  task automatic drive(input string s, input int maxgap);
    int cc[$];
    for (int i = 0; i < s.len(); i++) begin
      int g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      repeat (g) begin rx_valid = 1'b0; rx_data = 8'($urandom); @(negedge clk_in); end
      rx_data = s[i]; rx_valid = 1'b1; cc.push_back(cyc + 1); last_cc = cyc + 1;
      @(negedge clk_in);
    end
    rx_valid = 1'b0;
    model(s, cc);
    repeat (3) @(negedge clk_in);
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk_in);
    checks++;
    if ({ram_write_enable, ram_clk_enable, busy, line_done, error} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b required 00000",
                         {ram_write_enable, ram_clk_enable, busy, line_done, error});
    end
    checks++;
    if (ram_address !== '0 || ram_data_out !== 8'h00 || lines_loaded !== 8'h00) begin
      errors++; $display("FAIL reset_values: got addr=%h dat=%h lines=%0d required 0/0/0",
                         ram_address, ram_data_out, lines_loaded);
    end
    reset = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic test_full_line();
    string s = "L05";
    clear_obs();
    for (int i = 0; i < BPL / 2; i++) s = {s, "A1B2"};
    s = {s, "\n"};
    drive(s, 2);
    checks++;
    if (obs_wr.size() != exp_wr.size()) begin
      errors++; $display("FAIL full_line_wr_count: got %0d required %0d", obs_wr.size(), exp_wr.size());
    end
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) begin
      checks++;
      if (obs_wr[i] !== exp_wr[i]) begin
        errors++; $display("FAIL full_line_wr[%0d]: got cyc=%0d addr=%h dat=%h required cyc=%0d addr=%h dat=%h",
                           i, obs_wr[i].cyc, obs_wr[i].addr, obs_wr[i].dat, exp_wr[i].cyc, exp_wr[i].addr, exp_wr[i].dat);
      end
    end
    checks++;
    if (obs_done.size() != 1 || exp_done.size() != 1 || obs_done[0] != exp_done[0] || obs_err.size() != 0) begin
      errors++; $display("FAIL full_line_done: got %0d pulses (%0d errors) required one at cycle %0d",
                         obs_done.size(), obs_err.size(), (exp_done.size() > 0) ? exp_done[0] : -1);
    end
    checks++;
    if (lines_loaded !== exp_lines || busy !== 1'b0) begin
      errors++; $display("FAIL full_line_count: got lines=%0d busy=%b required lines=%0d busy=0",
                         lines_loaded, busy, exp_lines);
    end
  endtask

  task automatic test_bad_row();
    string s;
    clear_obs();
    s = {"L32", "L3x", $sformatf("L%02d", $urandom_range(99, ROWS)), "LZ"};
    drive(s, 2);
    checks++;
    if (obs_wr.size() != 0) begin
      errors++; $display("FAIL bad_row_writes: got %0d writes required 0", obs_wr.size());
    end
    checks++;
    if (obs_err.size() != exp_err.size()) begin
      errors++; $display("FAIL bad_row_err_count: got %0d required %0d", obs_err.size(), exp_err.size());
    end
    for (int i = 0; i < obs_err.size() && i < exp_err.size(); i++) begin
      checks++;
      if (obs_err[i] != exp_err[i]) begin
        errors++; $display("FAIL bad_row_err[%0d]: got cycle %0d required %0d", i, obs_err[i], exp_err[i]);
      end
    end
    checks++;
    if (busy !== 1'b0 || lines_loaded !== exp_lines) begin
      errors++; $display("FAIL bad_row_idle: got busy=%b lines=%0d required busy=0 lines=%0d", busy, lines_loaded, exp_lines);
    end
  endtask

  task automatic test_abort_then_line();
    clear_obs();
    drive({"L01", rhex(10), "G", "L01", rhex(BPL), "\r\n"}, 1);
    checks++;
    if (obs_wr.size() != exp_wr.size()) begin
      errors++; $display("FAIL abort_wr_count: got %0d required %0d", obs_wr.size(), exp_wr.size());
    end
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) begin
      checks++;
      if (obs_wr[i] !== exp_wr[i]) begin
        errors++; $display("FAIL abort_wr[%0d]: got cyc=%0d addr=%h dat=%h required cyc=%0d addr=%h dat=%h",
                           i, obs_wr[i].cyc, obs_wr[i].addr, obs_wr[i].dat, exp_wr[i].cyc, exp_wr[i].addr, exp_wr[i].dat);
      end
    end
    checks++;
    if (obs_err.size() != 1 || exp_err.size() != 1 || obs_err[0] != exp_err[0]) begin
      errors++; $display("FAIL abort_err: got %0d pulses required one at cycle %0d",
                         obs_err.size(), (exp_err.size() > 0) ? exp_err[0] : -1);
    end
    checks++;
    if (obs_done.size() != 1 || exp_done.size() != 1 || obs_done[0] != exp_done[0] || lines_loaded !== exp_lines) begin
      errors++; $display("FAIL abort_recover: got %0d done pulses lines=%0d required 1 lines=%0d",
                         obs_done.size(), lines_loaded, exp_lines);
    end
  endtask

  task automatic test_timeout();
    clear_obs();
    drive({"L07", rhex(2)}, 1);
    repeat (TMO - 100) @(negedge clk_in);
    checks++;
    if (busy !== 1'b1 || obs_err.size() != 0) begin
      errors++; $display("FAIL timeout_early: got busy=%b errors=%0d required busy=1 errors=0", busy, obs_err.size());
    end
    repeat (200) @(negedge clk_in);
    checks++;
    if (obs_err.size() != 1 || obs_err[0] < last_cc + TMO || obs_err[0] > last_cc + TMO + 1) begin
      errors++; $display("FAIL timeout_err: got %0d pulses first at %0d required one at %0d",
                         obs_err.size(), (obs_err.size() > 0) ? obs_err[0] : -1, last_cc + TMO);
    end
    checks++;
    if (obs_wr.size() != exp_wr.size() || busy !== 1'b0 || pending != 1'b1) begin
      errors++; $display("FAIL timeout_state: got writes=%0d busy=%b required writes=%0d busy=0",
                         obs_wr.size(), busy, exp_wr.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    drive({"L00", rhex(3)}, 1);
    checks++;
    if (obs_wr.size() != 3 || exp_wr.size() != 3 || obs_wr[2] !== exp_wr[2]) begin
      errors++; $display("FAIL reset_mid_prefix: got %0d writes required 3", obs_wr.size());
    end
    reset = 1'b1;
    @(negedge clk_in);
    checks++;
    if ({ram_write_enable, ram_clk_enable, busy, line_done, error} !== 5'b0 || ram_address !== '0 ||
        ram_data_out !== 8'h00 || lines_loaded !== 8'h00) begin
      errors++; $display("FAIL reset_mid_outputs: got flags=%b addr=%h dat=%h lines=%0d required all 0",
                         {ram_write_enable, ram_clk_enable, busy, line_done, error}, ram_address, ram_data_out, lines_loaded);
    end
    reset = 1'b0;
    exp_lines = 8'd0;
    clear_obs();
    drive({"L31", rhex(BPL), "\n"}, 1);
    checks++;
    if (obs_wr.size() != exp_wr.size()) begin
      errors++; $display("FAIL row31_wr_count: got %0d required %0d", obs_wr.size(), exp_wr.size());
    end
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) begin
      checks++;
      if (obs_wr[i] !== exp_wr[i]) begin
        errors++; $display("FAIL row31_wr[%0d]: got cyc=%0d addr=%h dat=%h required cyc=%0d addr=%h dat=%h",
                           i, obs_wr[i].cyc, obs_wr[i].addr, obs_wr[i].dat, exp_wr[i].cyc, exp_wr[i].addr, exp_wr[i].dat);
      end
    end
    checks++;
    if (obs_err.size() != 0 || obs_done.size() != 1 || lines_loaded !== exp_lines) begin
      errors++; $display("FAIL row31_done: got errors=%0d done=%0d lines=%0d required 0/1/%0d",
                         obs_err.size(), obs_done.size(), lines_loaded, exp_lines);
    end
  endtask

  task automatic test_garbage_lowercase();
    string s = {"xyz\r\n", "L02"};
    clear_obs();
    for (int i = 0; i < BPL; i++) s = {s, "ff"};
    s = {s, "\r\n"};
    drive(s, 1);
    checks++;
    if (obs_wr.size() != exp_wr.size()) begin
      errors++; $display("FAIL lower_wr_count: got %0d required %0d", obs_wr.size(), exp_wr.size());
    end
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) begin
      checks++;
      if (obs_wr[i] !== exp_wr[i]) begin
        errors++; $display("FAIL lower_wr[%0d]: got cyc=%0d addr=%h dat=%h required cyc=%0d addr=%h dat=%h",
                           i, obs_wr[i].cyc, obs_wr[i].addr, obs_wr[i].dat, exp_wr[i].cyc, exp_wr[i].addr, exp_wr[i].dat);
      end
    end
    checks++;
    if (obs_err.size() != 0 || obs_done.size() != 1 || exp_done.size() != 1 || obs_done[0] != exp_done[0]) begin
      errors++; $display("FAIL lower_done: got errors=%0d done=%0d required 0/1", obs_err.size(), obs_done.size());
    end
  endtask

  task automatic test_back_to_back_wrap();
    int need = 256 - int'(exp_lines);
    int bad = 0;
    for (int k = 0; k < need; k++) begin
      clear_obs();
      drive({$sformatf("L%02d", $urandom_range(ROWS - 1, 0)), rhex(BPL), "\n"}, 0);
      if (obs_wr.size() != exp_wr.size() || obs_err.size() != 0 || obs_done.size() != 1 ||
          exp_done.size() != 1 || obs_done[0] != exp_done[0]) bad++;
      else
        for (int i = 0; i < obs_wr.size(); i++) if (obs_wr[i] !== exp_wr[i]) bad++;
      if (exp_lines == 8'd255) begin
        checks++;
        if (lines_loaded !== exp_lines) begin
          errors++; $display("FAIL wrap_255: got lines=%0d required %0d", lines_loaded, exp_lines);
        end
      end
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL b2b_lines: got %0d bad writes/pulses required 0", bad);
    end
    checks++;
    if (lines_loaded !== exp_lines) begin
      errors++; $display("FAIL wrap_0: got lines=%0d required %0d", lines_loaded, exp_lines);
    end
  endtask

  task automatic test_pulse_rules();
    checks++;
    if (ce_bad != 0 || both_bad != 0) begin
      errors++; $display("FAIL pulse_rules: got ce_mismatch=%0d overlap=%0d required 0/0", ce_bad, both_bad);
    end
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    @(negedge clk_in);
    test_reset();
    test_full_line();
    test_bad_row();
    test_abort_then_line();
    test_timeout();
    test_reset_mid();
    test_garbage_lowercase();
    test_back_to_back_wrap();
    test_pulse_rules();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/line_loader.md
Name: line_loader

Overview:
- Parses ASCII line commands from the image-data UART receiver and writes framebuffer bytes into port A of the dual-port frame memory.
- Sits directly upstream of the frame memory's write port.
- Command format: 'L', two ASCII decimal row digits, 2×BYTES_PER_LINE hex characters (high nibble first per byte), then '\n'.
- Downstream, the framebuffer fetch stage reads the same memory as 16-bit words on port B.

Parameters:
- ROWS, 32, number of addressable lines; row numbers 0..ROWS-1 are valid.
- BYTES_PER_LINE, 128, bytes per line (64 columns × RGB565); power of 2.
- ADDR_WIDTH, 12, RAM byte-address width; ROWS*BYTES_PER_LINE must equal 2^ADDR_WIDTH or less.
- TIMEOUT_TICKS, 4095, maximum clk_in cycles between characters while a command is in progress.
- TIMEOUT_WIDTH, 12, counter width for TIMEOUT_TICKS.

Ports:
- clk_in  in  1  system clock (clk_root domain).
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle. Back-to-back strobes are legal.
- ram_data_out  out  8  write data to RAM port A.
- ram_address  out  ADDR_WIDTH  byte address to RAM port A.
- ram_write_enable  out  1  one-cycle write strobe.
- ram_clk_enable  out  1  asserted together with ram_write_enable.
- busy  out  1  high whenever the state is not IDLE.
- line_done  out  1  one-cycle pulse when a line is accepted.
- error  out  1  one-cycle pulse when a command is aborted.
- lines_loaded  out  8  count of accepted lines; wraps 255→0.

Behaviour:
- Clock and reset:
  - Single clock clk_in; reset is synchronous, active-high.
  - Reset forces all outputs to 0, the state to IDLE, and the byte index, nibble latch and timeout counter to 0.
  - Reset mid-command aborts the command with no further writes; bytes already written stay in RAM. Reset does not pulse error.
- States: IDLE, ROW_HI, ROW_LO, DATA_HI, DATA_LO, TERM. Transitions happen only on rx_valid unless noted.
- IDLE:
  - 'L' (0x4C) → ROW_HI.
  - Any other byte, including CR and LF, is ignored.
- ROW_HI / ROW_LO:
  - '0'-'9' accepted; row = 10*hi + lo.
  - Non-digit → error, IDLE.
  - After ROW_LO, if row ≥ ROWS → error, IDLE, no writes.
  - Otherwise byte index = 0 → DATA_HI.
- DATA_HI:
  - Accepts '0'-'9', 'A'-'F' and 'a'-'f'; the nibble is latched → DATA_LO.
  - Anything else → error, IDLE.
- DATA_LO:
  - A valid hex character forms byte {hi, lo}.
  - On the next cycle: ram_write_enable = ram_clk_enable = 1 for exactly one cycle, ram_data_out = byte, ram_address = row*BYTES_PER_LINE + index (concatenation {row, index}).
  - Then index increments.
  - If the index was BYTES_PER_LINE-1 → TERM; else → DATA_HI.
  - A non-hex character → error, IDLE, and that byte is not written.
- Write latency and hold:
  - Exactly 1 cycle from the second-nibble rx_valid to the write strobe.
  - A back-to-back rx_valid during the write cycle is processed normally.
  - ram_data_out and ram_address hold their last values when not writing.
- TERM:
  - '\n' (0x0A) → line_done pulse on the following cycle, lines_loaded+1, IDLE.
  - '\r' (0x0D) is ignored, staying in TERM.
  - Any other byte → error, IDLE. All written bytes remain.
- Timeout:
  - In any non-IDLE state, the counter clears on each rx_valid and increments otherwise.
  - When it reaches TIMEOUT_TICKS → error pulse, IDLE.
  - Counter is held at 0 in IDLE.
- Pulse rules:
  - error and line_done are never asserted in the same cycle.
  - error is asserted the cycle after the offending character or the timeout.

Test Plan:
1. "L05" + ("A1B2"×64) + "\n" → 128 writes to 0x280..0x2FF, data alternating 0xA1/0xB2, one write per byte; line_done pulses once; lines_loaded=1; busy low afterwards.
2. "L32" → error pulse one cycle after '2'; no ram_write_enable; state IDLE. "L3x" → error after 'x'.
3. "L01", 10 valid hex bytes, then 'G' → exactly 10 writes at 0x080..0x089, error pulse, IDLE. A following full valid line for row 01 completes with line_done.
4. "L07" + 4 hex chars, then silence for 4095 cycles → error pulse at tick 4095, busy drops, no extra write.
5. "L00" + 3 bytes, then assert reset for 1 cycle → all outputs 0 and lines_loaded=0. A new valid line for row 31 writes 0xF80..0xFFF.
6. Garbage "xyz\r\n" then "L02" + "ff"×128 + "\r\n" → garbage ignored; lowercase accepted (data 0xFF at 0x100..0x17F); line_done once. Repeat 256 lines → lines_loaded wraps to 0.
